// File: rtl/piradip_axi4_pkg.sv
// Shared AXI4 protocol types and constants used by the piradip AXI4 masters and slaves.
package piradip_axi4;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10
    } axi_burst_t;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_resp_t;

endpackage

// File: rtl/piradip_axis_axi4_dma_writer_pkg.sv
// State encoding and burst sizing shared by the stream-to-memory DMA (and a future read DMA).
package piradip_axis_axi4_dma_writer_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_DATA = 3'd2,
        S_RESP = 3'd3,
        S_DONE = 3'd4
    } dma_state_t;

    // Beats in the next burst: limited by what is left, the burst cap and the next 4 KB page.
    // addr_lo must already be aligned to the beat size, so at least one beat always fits.
    function automatic logic [8:0] calc_blen(input logic [11:0]  addr_lo,
                                             input logic [15:0]  remaining,
                                             input int unsigned  max_len,
                                             input int unsigned  size_log2);
        logic [12:0] to_4k;
        logic [16:0] b;
        to_4k = (13'h1000 - {1'b0, addr_lo}) >> size_log2;
        b = {1'b0, remaining};
        if (17'(max_len) < b) b = 17'(max_len);
        if ({4'b0, to_4k} < b) b = {4'b0, to_4k};
        return b[8:0];
    endfunction

endpackage

// File: rtl/piradip_axis_axi4_dma_writer.sv
// Stream-to-memory write DMA: turns an AXI4-Stream into AXI4 INCR write bursts over a contiguous region.
module piradip_axis_axi4_dma_writer
    import piradip_axi4::*;
    import piradip_axis_axi4_dma_writer_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [15:0]             xfer_beats,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              error,
    input  logic [DATA_WIDTH-1:0]   s_tdata,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    input  logic                    s_tlast,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic [7:0]              m_awlen,
    output logic [2:0]              m_awsize,
    output logic [1:0]              m_awburst,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic                    m_wlast,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    input  logic [1:0]              m_bresp,
    input  logic                    m_bvalid,
    output logic                    m_bready,
    output logic [2:0]              dbg_state
);

    localparam int SIZE_LOG2 = $clog2(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        ~((ADDR_WIDTH'(1) << SIZE_LOG2) - ADDR_WIDTH'(1));

    dma_state_t            state_q;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [7:0]            awlen_q;
    logic                  awvalid_q, bready_q, busy_q, done_q;
    logic [1:0]            error_q;
    logic [15:0]           remaining_q;
    logic [8:0]            blen_q, beat_q;

    logic [ADDR_WIDTH-1:0] start_addr_d, next_addr_d;
    logic [15:0]           next_rem_d;
    logic [8:0]            first_blen_d, next_blen_d;
    logic                  w_fire, last_of_xfer;

    assign start_addr_d = base_addr & ALIGN_MASK;
    assign next_addr_d  = awaddr_q + (ADDR_WIDTH'(blen_q) << SIZE_LOG2);
    assign next_rem_d   = remaining_q - 16'(blen_q);
    assign first_blen_d = calc_blen(start_addr_d[11:0], xfer_beats, MAX_BURST_LEN, SIZE_LOG2);
    assign next_blen_d  = calc_blen(next_addr_d[11:0], next_rem_d, MAX_BURST_LEN, SIZE_LOG2);

    // W channel is a straight pass-through of the stream while a burst is open.
    assign m_wvalid     = (state_q == S_DATA) && s_tvalid;
    assign s_tready     = (state_q == S_DATA) && m_wready;
    assign m_wdata      = s_tdata;
    assign m_wstrb      = '1;
    assign m_wlast      = (state_q == S_DATA) && (beat_q == blen_q - 9'd1);
    assign w_fire       = m_wvalid && m_wready;
    assign last_of_xfer = m_wlast && (remaining_q == {7'b0, blen_q});

    assign m_awaddr  = awaddr_q;
    assign m_awlen   = awlen_q;
    assign m_awsize  = 3'(SIZE_LOG2);
    assign m_awburst = AXI_BURST_INCR;
    assign m_awvalid = awvalid_q;
    assign m_bready  = bready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign dbg_state = state_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= S_IDLE;
            awaddr_q    <= '0;
            awlen_q     <= '0;
            awvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= '0;
            remaining_q <= '0;
            blen_q      <= '0;
            beat_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        error_q <= '0;
                        busy_q  <= 1'b1;
                        if (xfer_beats == 16'd0) begin
                            state_q <= S_DONE;
                        end else begin
                            awaddr_q    <= start_addr_d;
                            remaining_q <= xfer_beats;
                            blen_q      <= first_blen_d;
                            awlen_q     <= 8'(first_blen_d - 9'd1);
                            awvalid_q   <= 1'b1;
                            state_q     <= S_ADDR;
                        end
                    end
                end
                S_ADDR: begin
                    if (m_awready) begin
                        awvalid_q <= 1'b0;
                        beat_q    <= '0;
                        state_q   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_fire) begin
                        if (s_tlast != last_of_xfer) error_q[1] <= 1'b1;
                        if (m_wlast) begin
                            bready_q <= 1'b1;
                            state_q  <= S_RESP;
                        end else begin
                            beat_q <= beat_q + 9'd1;
                        end
                    end
                end
                S_RESP: begin
                    if (m_bvalid) begin
                        bready_q <= 1'b0;
                        if (m_bresp != AXI_RESP_OKAY || next_rem_d == 16'd0) begin
                            if (m_bresp != AXI_RESP_OKAY) error_q[0] <= 1'b1;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_DONE;
                        end else begin
                            awaddr_q    <= next_addr_d;
                            remaining_q <= next_rem_d;
                            blen_q      <= next_blen_d;
                            awlen_q     <= 8'(next_blen_d - 9'd1);
                            awvalid_q   <= 1'b1;
                            state_q     <= S_ADDR;
                        end
                    end
                end
                S_DONE: begin
                    // A zero-beat start arrives here with done still low and spends one extra cycle.
                    if (!done_q) begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end else begin
                        done_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/piradip_axis_axi4_dma_writer.md
# piradip_axis_axi4_dma_writer

Stream-to-memory write DMA: accepts an AXI4-Stream of data words and writes them as AXI4 INCR bursts to a contiguous memory region. It is the upstream master that fills AXI4-attached RAM with captured samples. Transfers are triggered by a start pulse and report completion and errors through status outputs. Only the write channels (AW/W/B) are driven; the read channels are not part of this block.

## Interface
Parameters:
- DATA_WIDTH, 32, stream and AXI data width in bits; power of two, at least 8.
- ADDR_WIDTH, 32, AXI address width.
- MAX_BURST_LEN, 16, maximum beats per burst; 1 to 256.

Ports:
- aclk  in  1  clock; one clock, all logic on its rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  start byte address, latched on start.
- xfer_beats  in  16  total beats, latched on start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- error  out  2  sticky; bit0 = non-OKAY bresp, bit1 = tlast mismatch; cleared on an accepted start.
- s_tdata  in  DATA_WIDTH; s_tvalid  in  1; s_tready  out  1; s_tlast  in  1  AXI4-Stream slave.
- m_awaddr  out  ADDR_WIDTH; m_awlen  out  8; m_awsize  out  3; m_awburst  out  2; m_awvalid  out  1; m_awready  in  1.
- m_wdata  out  DATA_WIDTH; m_wstrb  out  DATA_WIDTH/8; m_wlast  out  1; m_wvalid  out  1; m_wready  in  1.
- m_bresp  in  2; m_bvalid  in  1; m_bready  out  1.

Reset values: all valid, ready, busy, done and error outputs are 0. m_awaddr and m_awlen are 0. m_awsize is the constant clog2(DATA_WIDTH/8). m_awburst is the constant INCR. m_wstrb is the constant all-ones.

## Operation
State machine: IDLE, ADDR, DATA, RESP, DONE.

- **IDLE**
  - start with xfer_beats = 0: go to DONE directly, with no bus activity.
  - start with xfer_beats > 0: latch the address with its low clog2(DATA_WIDTH/8) bits forced to 0, load remaining = xfer_beats, and go to ADDR.
- **ADDR**
  - Burst length: blen = min(remaining, MAX_BURST_LEN, beats_to_4k), where beats_to_4k = (4096 − addr[11:0]) >> clog2(DATA_WIDTH/8).
  - Drive m_awlen = blen − 1 and hold m_awvalid until m_awready; on the handshake go to DATA.
- **DATA**
  - Pass-through: m_wvalid = s_tvalid, s_tready = m_wready, m_wdata = s_tdata.
  - A beat is counted on m_wvalid & m_wready.
  - m_wlast is asserted on beat blen of the burst; after that beat go to RESP.
- **RESP**
  - m_bready = 1. On m_bvalid, if m_bresp ≠ OKAY, set error[0] and go to DONE (the transfer is aborted).
  - Otherwise addr += blen × DATA_WIDTH/8 (wraps modulo 2^ADDR_WIDTH) and remaining −= blen.
  - If remaining = 0 go to DONE, else go to ADDR.
- **DONE**
  - Assert done for one cycle, deassert busy, return to IDLE.
- **tlast check**
  - error[1] sets if s_tlast = 1 on an accepted beat that is not the final beat of the transfer.
  - error[1] also sets if s_tlast = 0 on the final beat.
  - The transfer continues regardless of a tlast mismatch.
- start outside IDLE is ignored.
- s_tready = 0 outside DATA.
- Asynchronous reset mid-operation forces IDLE immediately and deasserts all valids, readies, busy and done. Partial bursts are abandoned with no recovery.

## Timing
- start accepted at edge N: busy = 1 and m_awvalid = 1 from cycle N+1.
- The W channel opens the cycle after the AW handshake. No W beat is ever issued before its AW.
- Sustained throughput in DATA is 1 beat per cycle when s_tvalid and m_wready are both high.
- After m_wlast is accepted, m_bready rises the following cycle.
- After the final B handshake, done pulses in the next cycle. busy falls in the same cycle as done.
- Per-burst overhead is 2 cycles plus slave B latency.
- m_awaddr, m_awlen and m_awvalid are registered outputs. m_wvalid, m_wdata and s_tready are combinational pass-through.
- A zero-beat start produces done 2 cycles after the start edge, and busy is high for 1 cycle.

## Structure
- Use the existing shared piradip_axi4 package for the burst and response types and the INCR and OKAY constants.
- Add a package function that computes blen from address, remaining and MAX_BURST_LEN, so it is reusable by a future read DMA.
- No sub-module; the design is a single FSM with a datapath.

## Test plan
- **Single burst:** base 0x000, 16 beats, stream 0..15 with tlast on beat 16 → one AW (awlen = 15); memory holds 0..15; done; error = 0.
- **Multi-burst with remainder:** 40 beats, MAX_BURST_LEN = 16 → awlen sequence 15, 15, 7; addresses 0x000, 0x040, 0x080.
- **4 KB boundary split:** base 0xFF8, 8 beats, 32-bit data → bursts of 2 beats at 0xFF8 and 6 beats at 0x1000.
- **Backpressure:** random gaps on s_tvalid and m_wready, awready delayed 5 cycles → data intact, no beat before AW, m_wlast exactly on beat blen.
- **Error paths:**
  - bresp = SLVERR on the second of three bursts → error[0] = 1, done, no third AW.
  - Early tlast on beat 3 of 8 → error[1] = 1; all 8 beats are still written.
- **Reset and edge cases:**
  - aresetn low during DATA → all valids 0 within the same cycle; idle after release; a new start works.
  - xfer_beats = 0 → done with no AW.
